// File: rtl/cgp_out_profiler.sv
// Observes the single-bit output of the evolved CGP circuit over WINDOW cycles and
// reports ones count, toggle count, longest constant run and a constant flag via valid/ack.
module cgp_out_profiler #(
  parameter int unsigned WINDOW = 64,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             out_0,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] max_run,
  output logic             is_const
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] ones_d, toggle_d, max_d;
  logic             const_d, busy_d, valid_d;
  logic             chg_c;

  // State and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      run_q      <= '0;
      prev_q     <= 1'b0;
      ones_cnt   <= '0;
      toggle_cnt <= '0;
      max_run    <= '0;
      is_const   <= 1'b1;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      run_q      <= run_d;
      prev_q     <= prev_d;
      ones_cnt   <= ones_d;
      toggle_cnt <= toggle_d;
      max_run    <= max_d;
      is_const   <= const_d;
      busy       <= busy_d;
      res_valid  <= valid_d;
    end
  end

  // Next state and datapath update
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    run_d    = run_q;
    prev_d   = prev_q;
    ones_d   = ones_cnt;
    toggle_d = toggle_cnt;
    max_d    = max_run;
    const_d  = is_const;
    busy_d   = busy;
    valid_d  = res_valid;
    chg_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MEASURE;
          idx_d    = '0;
          run_d    = '0;
          prev_d   = 1'b0;
          ones_d   = '0;
          toggle_d = '0;
          max_d    = '0;
          const_d  = 1'b1;
          busy_d   = 1'b1;
          valid_d  = 1'b0;
        end
      end
      MEASURE: begin
        // The very first sample has no predecessor, so it can never count as a change
        chg_c    = (idx_q != '0) && (out_0 != prev_q);
        ones_d   = ones_cnt + CNT_W'(out_0);
        toggle_d = toggle_cnt + CNT_W'(chg_c);
        const_d  = is_const & ~chg_c;
        run_d    = chg_c ? ONE : run_q + ONE;
        max_d    = (run_d > max_run) ? run_d : max_run;
        prev_d   = out_0;
        idx_d    = idx_q + ONE;
        if (idx_q == LAST_IDX) begin
          state_d = REPORT;
          valid_d = 1'b1;
        end
      end
      REPORT: begin
        if (res_ack) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cgp_out_profiler.sv
// Randomized self-checking bench for cgp_out_profiler; expected signatures come from a
// pattern-level model (popcount, xor-popcount, brute-force longest run).
module tb_cgp_out_profiler;

  localparam int unsigned W     = 64;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, out_0, res_ack;
  logic             busy, res_valid, is_const;
  logic [CNT_W-1:0] ones_cnt, toggle_cnt, max_run;

  logic             start2, out2, ack2;
  logic             busy2, valid2, const2;
  logic [CNT_W-1:0] ones2, tog2, max2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cgp_out_profiler #(.WINDOW(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .out_0(out_0), .busy(busy),
    .res_valid(res_valid), .res_ack(res_ack), .ones_cnt(ones_cnt),
    .toggle_cnt(toggle_cnt), .max_run(max_run), .is_const(is_const)
  );

  cgp_out_profiler #(.WINDOW(2), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .out_0(out2), .busy(busy2),
    .res_valid(valid2), .res_ack(ack2), .ones_cnt(ones2),
    .toggle_cnt(tog2), .max_run(max2), .is_const(const2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Longest stretch of equal bits, found by extending from every start position
  function automatic int longest_run(input logic [W-1:0] pat);
    int best = 0;
    for (int i = 0; i < int'(W); i++) begin
      int j = i;
      while (j < int'(W) && pat[j] == pat[i]) j++;
      if (j - i > best) best = j - i;
    end
    return best;
  endfunction

  task automatic check_results(input string tag, input logic [W-1:0] pat);
    int e_ones, e_tog, e_max;
    logic [W-1:0] diffs;
    diffs  = (pat ^ (pat >> 1)) & {1'b0, {(W-1){1'b1}}};
    e_ones = $countones(pat);
    e_tog  = $countones(diffs);
    e_max  = longest_run(pat);
    check({tag, "_ones"}, 32'(ones_cnt), 32'(e_ones));
    check({tag, "_tog"},  32'(toggle_cnt), 32'(e_tog));
    check({tag, "_max"},  32'(max_run), 32'(e_max));
    check({tag, "_const"}, 32'(is_const), 32'(e_tog == 0));
  endtask

  // Runs one measurement; pat[i] is the sample taken at edge E(i+1).
  // Called and returns at posedge+1. ack_start leaves start high after the ack edge.
  task automatic run_measure(input string tag, input logic [W-1:0] pat,
                             input int hold, input bit ack_start);
    bit early = 0, unstable = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_0 = pat[0];
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    for (int i = 1; i < int'(W); i++) begin
      @(posedge clk); #1;
      out_0 = pat[i];
      start = 1'($urandom_range(1));
      if (res_valid) early = 1;
    end
    @(posedge clk); #1;
    check({tag, "_early_valid"}, 32'(early), 32'd0);
    check({tag, "_valid_at_W"}, 32'(res_valid), 32'd1);
    check_results(tag, pat);
    for (int k = 0; k < hold; k++) begin
      start = 1'($urandom_range(1));
      @(posedge clk); #1;
      if (!res_valid || !busy) unstable = 1;
    end
    if (hold > 0) begin
      check({tag, "_hold_valid"}, 32'(unstable), 32'd0);
      check_results({tag, "_hold"}, pat);
    end
    res_ack = 1'b1;
    start   = ack_start;
    @(posedge clk); #1;
    res_ack = 1'b0;
    check({tag, "_ack_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_ack_busy"}, 32'(busy), 32'd0);
    check_results({tag, "_idle"}, pat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat;
    reset = 1'b0; start = 1'b0; out_0 = 1'b0; res_ack = 1'b0;
    start2 = 1'b0; out2 = 1'b0; ack2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_ones", 32'(ones_cnt), 32'd0);
    check("rst_tog", 32'(toggle_cnt), 32'd0);
    check("rst_max", 32'(max_run), 32'd0);
    check("rst_const", 32'(is_const), 32'd1);
    reset = 1'b1;

    // Minimum window: samples 0 then 1
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; out2 = 1'b0;
    @(posedge clk); #1;
    out2 = 1'b1;
    check("w2_early_valid", 32'(valid2), 32'd0);
    @(posedge clk); #1;
    check("w2_valid", 32'(valid2), 32'd1);
    check("w2_ones", 32'(ones2), 32'd1);
    check("w2_tog", 32'(tog2), 32'd1);
    check("w2_max", 32'(max2), 32'd1);
    check("w2_const", 32'(const2), 32'd0);
    ack2 = 1'b1;
    @(posedge clk); #1;
    ack2 = 1'b0;
    check("w2_ack_valid", 32'(valid2), 32'd0);

    run_measure("zeros", '0, 20, 1'b0);
    run_measure("alt", {32{2'b01}}, 0, 1'b1);
    run_measure("ten_ones", 64'h3FF, 0, 1'b0);
    run_measure("ones", '1, 3, 1'b0);

    // Abort at sample 30 with an asynchronous reset between clock edges
    pat = {$urandom, $urandom} | 64'h1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      out_0 = pat[i];
      @(posedge clk); #1;
    end
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_ones", 32'(ones_cnt), 32'd0);
    check("abort_tog", 32'(toggle_cnt), 32'd0);
    check("abort_max", 32'(max_run), 32'd0);
    check("abort_const", 32'(is_const), 32'd1);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    run_measure("post_abort", {$urandom, $urandom}, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      case (t % 3)
        0: pat = {$urandom, $urandom};
        1: pat = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: pat = {$urandom, $urandom} | {$urandom, $urandom} | {$urandom, $urandom};
      endcase
      run_measure($sformatf("rnd%0d", t), pat, int'($urandom_range(4)), 1'($urandom_range(1)));
    end
    start = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cgp_out_profiler.md
# cgp_out_profiler

Measurement stage directly downstream of the evolved CGP circuit. It samples that circuit's single-bit output `out_0` over a fixed window of clock cycles and reduces the stream to a small signature: ones count, toggle count, longest constant run, and a constant-output flag. The signature is presented to the evaluation/fitness logic through a valid/ack handshake. The evolved circuit itself is left unmodified; the profiler is a pure observer of its output.

## Interface
- `WINDOW`, default 64: number of `out_0` samples per measurement. Legal range is 2 ≤ `WINDOW` ≤ 2^`CNT_W` − 1.
- `CNT_W`, default 16: width of every result counter. Must hold `WINDOW`; no saturation logic exists.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to begin a measurement; honoured only in IDLE.
- `out_0`  in  1  output of the CGP circuit under evaluation; synchronous to `clk`.
- `busy`  out  1  high in MEASURE and REPORT.
- `res_valid`  out  1  high in REPORT; the result outputs are stable while it is high.
- `res_ack`  in  1  consumer acknowledge; honoured only while `res_valid` = 1.
- `ones_cnt`  out  `CNT_W`  number of samples equal to 1.
- `toggle_cnt`  out  `CNT_W`  number of sample-to-sample value changes.
- `max_run`  out  `CNT_W`  length of the longest run of identical consecutive samples.
- `is_const`  out  1  1 when `toggle_cnt` = 0.

## Operation
- FSM states: IDLE, MEASURE, REPORT. Encoding is free.
- IDLE: `start` = 1 at an edge moves to MEASURE. On the same edge, clear the sample index, `ones_cnt`, `toggle_cnt`, `max_run`, the current-run register, and the previous-sample register.
- MEASURE: on each edge, sample `out_0` as `s` and update:
  - `ones_cnt` += `s`.
  - If index > 0 and `s` ≠ prev: `toggle_cnt` += 1.
  - run = 1 if index > 0 and `s` ≠ prev; otherwise run = run + 1.
  - `max_run` = max(`max_run`, new run).
  - prev = `s`; index += 1.
- MEASURE exit: the edge that takes sample number `WINDOW` also moves to REPORT.
- REPORT:
  - `res_valid` = 1 and all result outputs are frozen.
  - `res_ack` = 1 at an edge moves to IDLE. Result outputs keep their values in IDLE until the next accepted `start`.
- `start` is ignored in MEASURE and REPORT. It is not queued.
- `res_ack` outside REPORT has no effect.
- Simultaneous `res_ack` and `start` in REPORT: only the ack is taken. A `start` still high on the following edge (now in IDLE) begins a new measurement.
- Invariants at REPORT: `ones_cnt` ≤ `WINDOW`; `toggle_cnt` ≤ `WINDOW` − 1; 1 ≤ `max_run` ≤ `WINDOW`.
- `reset` asserted at any time, including mid-measurement: immediately go to IDLE and clear all counters and registers to 0. `busy` = 0, `res_valid` = 0. The partial measurement is discarded.

## Timing
- Reset values: `busy` 0, `res_valid` 0, `ones_cnt` 0, `toggle_cnt` 0, `max_run` 0, `is_const` 1.
- Let `start` be accepted at edge E0. Then:
  - `busy` = 1 from after E0.
  - Samples are taken at edges E1 … E`WINDOW`.
  - `res_valid` = 1 from after E`WINDOW`, i.e. `WINDOW` cycles after the start edge.
- `res_ack` accepted at edge A: `res_valid` = 0 and `busy` = 0 after A. The earliest next `start` acceptance is edge A+1.
- All outputs are registered; no combinational path from any input to any output. `is_const` may be decoded from the `toggle_cnt` register.

## Test plan
- `out_0` held at 0, `WINDOW` = 64, `start` pulse:
  - `res_valid` rises exactly 64 cycles after the start edge.
  - Results: `ones_cnt` = 0, `toggle_cnt` = 0, `max_run` = 64, `is_const` = 1.
- `out_0` alternating 1,0,1,… starting with 1 at E1: `ones_cnt` = 32, `toggle_cnt` = 63, `max_run` = 1, `is_const` = 0.
- `out_0` = 1 for E1–E10, then 0 for the rest: `ones_cnt` = 10, `toggle_cnt` = 1, `max_run` = 54.
- Handshake:
  - Hold `res_ack` low for 20 cycles in REPORT: results and `res_valid` stay stable throughout.
  - Pulse `start` during MEASURE and REPORT: ignored.
  - Assert `res_ack` and `start` on the same edge: IDLE next; measurement begins one edge later.
- Assert `reset` low at sample 30 of a measurement:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - A following `start` yields a full, correct 64-sample result with no residue from the aborted run.
- `WINDOW` = 2 with `out_0` = 0,1: `ones_cnt` = 1, `toggle_cnt` = 1, `max_run` = 1, `res_valid` 2 cycles after start.
